multiface_ctrl: RTL
===================

// Module: multiface_ctrl
// PURPOSE
//  Parametrised Multiface-style freeze controller for the CPC core. Arms an NMI on a key press,
//  pages in its ROM/RAM on the NMI vector fetch, shadows every GA/CRTC/PPI/ROM-select I/O write
//  into its own RAM, and pages out via I/O. Sits beside the motherboard; its rom_en/ram_en outputs
//  steer the SDRAM mux, and its ram_dout is merged into the CPU read data.
// PARAMETERS
//  RAM_AW      13       shadow RAM address width (2^RAM_AW bytes, >=13); shadow map sits at RAM top
//  CRTC_REGS   16       CRTC registers shadowed (16 or 32)
//  NMI_VEC     16'h0066 M1 address that completes NMI entry and pages in
//  HIDE_VEC    16'h0065 M1 address (while paged in) that sets hidden
//  DEB_CYC     4096     key_nmi stable-level cycles (used only with MF_NMI_DEBOUNCE_EN)
// PORTS
//  clk_sys    in   1        system clock
//  reset      in   1        synchronous, active-high
//  key_nmi    in   1        freeze key level from keyboard
//  cpu_addr   in   16       Z80 address bus
//  m1         in   1        Z80 M1 (active-high)
//  io_wr      in   1        I/O write strobe level
//  io_dout    in   8        I/O write data
//  ram_w      in   1        memory write strobe level
//  ram_din    in   8        CPU memory write data
//  nmi        out  1        NMI request to CPU
//  mf_en      out  1        Multiface paged in
//  mf_hidden  out  1        paging-in via I/O locked out
//  rom_en     out  1        mf_en & cpu_addr[15:13]==0 (combinational)
//  ram_en     out  1        mf_en & cpu_addr[15:13]==1 (combinational)
//  ram_dout   out  8        shadow RAM read data, 1-cycle latency
// BEHAVIOUR
//  - Reset: nmi=0, mf_en=0, mf_hidden=0, pen_idx=0, crtc_idx=0, RAM write disabled. RAM contents kept.
//  - Edges: key_nmi, m1, io_wr rising edges detected against 1-cycle-delayed copies.
//  - FSM IDLE->ARMED on key_nmi rise while IDLE (nmi=1). ARMED->ACTIVE on m1 rise with
//    cpu_addr==NMI_VEC (nmi=0, mf_en=1, mf_hidden=0). ACTIVE: m1 rise at HIDE_VEC sets mf_hidden.
//    key_nmi rise in ARMED/ACTIVE ignored. reset from any state -> IDLE.
//  - Page port: io_wr rise with cpu_addr[15:2]==14'h3FBA: addr[1]=0 -> mf_en=~mf_hidden (IDLE->ACTIVE
//    if not hidden); addr[1]=1 -> mf_en=0, FSM IDLE. Never also a shadow store.
//  - Shadow store on io_wr rise; T=2^RAM_AW-1; offset k means address T-k:
//    7Fxx d[7:6]=00 pen select  k=0x30, pen_idx<=d[4:0]
//    7Fxx 01 colour: pen_idx[4] ? k=0x20 : k=0x6F-pen_idx[3:0]... stored at T-0x6F+pen_idx[3:0]
//    7Fxx 10 mode k=0x10; 7Fxx 11 banking k=0
//    BCxx CRTC select k=0x300, crtc_idx<=d[4:0] masked to log2(CRTC_REGS)
//    BDxx CRTC data at T-0x24F+crtc_idx; F7xx PPI ctrl k=0x800; DFxx ROM select k=0x553
//  - Port arbitration per cycle: page port > shadow store > CPU write (ram_w & ram_en, address
//    cpu_addr[12:0] zero-extended) > read. Write is one cycle wide; ram_dout returns the written byte.
//  - ram_dout valid one clk_sys after address; read-during-write returns new data.
//  - io_wr held high: single store only (edge based). Simultaneous m1 NMI_VEC entry and page-out
//    write in same cycle: page-out wins, FSM IDLE, nmi=0.
// CONFIGURATION
//  MF_NMI_DEBOUNCE_EN defined: key_nmi passes a 2-flop synchroniser and must hold a new level
//   DEB_CYC consecutive cycles before the filtered level changes; edge detect uses filtered level.
//  Undefined: 2-flop synchroniser only; edge on raw synchronised level; DEB_CYC unused.
// TESTING
//  1 key_nmi pulse, then m1 at 0x0066 -> nmi 1 until that M1, then nmi=0, mf_en=1, rom_en at 0x0000
//  2 OUT &7F00,&03; OUT &7F00,&54 -> RAM[T-0x30]=0x03, RAM[T-0x6C]=0x54 (RAM_AW=13: 0x1F93)
//  3 CRTC_REGS=32: OUT &BC00,&13; OUT &BD00,&AA -> RAM[0x1DC3]=0xAA; crtc_idx=0x13
//  4 ACTIVE, m1 at 0x0065, OUT &FEEA then OUT &FEE8 -> mf_en 0 and stays 0 (hidden)
//  5 ram_w at 0x2005 data 0x5A while mf_en -> read at 0x2005 next cycle returns 0x5A; mf_en=0 -> no write
//  6 MF_NMI_DEBOUNCE_EN, DEB_CYC=8: 5-cycle key_nmi glitch -> nmi stays 0; 8-cycle hold -> nmi=1

Source files
------------

// File: rtl/multiface_ctrl.sv
// Multiface-style freeze controller: NMI arming, page-in/out, shadow RAM of GA/CRTC/PPI/ROM writes.
// Optional key debounce filter enabled by defining MF_NMI_DEBOUNCE_EN.
module multiface_ctrl #(
    parameter int          RAM_AW    = 13,
    parameter int          CRTC_REGS = 16,
    parameter logic [15:0] NMI_VEC   = 16'h0066,
    parameter logic [15:0] HIDE_VEC  = 16'h0065,
    parameter int          DEB_CYC   = 4096
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        key_nmi,
    input  logic [15:0] cpu_addr,
    input  logic        m1,
    input  logic        io_wr,
    input  logic [7:0]  io_dout,
    input  logic        ram_w,
    input  logic [7:0]  ram_din,
    output logic        nmi,
    output logic        mf_en,
    output logic        mf_hidden,
    output logic        rom_en,
    output logic        ram_en,
    output logic [7:0]  ram_dout
);

    localparam logic [4:0]        CRTC_MASK = 5'(CRTC_REGS - 1);
    localparam logic [RAM_AW-1:0] TOP       = {RAM_AW{1'b1}};

    if (RAM_AW < 13 || DEB_CYC < 1 || !(CRTC_REGS == 16 || CRTC_REGS == 32)) begin : g_param_check
        $error("multiface_ctrl: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hidden_q, hidden_d;
    logic [4:0]  pen_idx_q, pen_idx_d;
    logic [4:0]  crtc_idx_q, crtc_idx_d;
    logic [1:0]  key_sync_q;
    logic        key_lvl, key_dly_q, m1_q, io_wr_q;
    logic        key_rise, m1_rise, io_rise;
    logic        page_hit, page_in, page_out;
    logic        shadow_we, cpu_we, mem_we;
    logic [RAM_AW-1:0] shadow_addr, mem_addr;
    logic [7:0]  mem_wdata, dout_q;
    logic [7:0]  mem [2**RAM_AW];

`ifdef MF_NMI_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYC + 1);
    logic             key_filt_q;
    logic [DEB_W-1:0] deb_cnt_q;

    // The filtered level only follows the synchroniser after DEB_CYC unbroken cycles of disagreement.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_filt_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else if (key_sync_q[1] == key_filt_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
            key_filt_q <= key_sync_q[1];
            deb_cnt_q  <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end
    assign key_lvl = key_filt_q;
`else
    assign key_lvl = key_sync_q[1];
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_sync_q <= '0;
            key_dly_q  <= 1'b0;
            m1_q       <= 1'b0;
            io_wr_q    <= 1'b0;
        end else begin
            key_sync_q <= {key_sync_q[0], key_nmi};
            key_dly_q  <= key_lvl;
            m1_q       <= m1;
            io_wr_q    <= io_wr;
        end
    end

    assign key_rise = key_lvl & ~key_dly_q;
    assign m1_rise  = m1 & ~m1_q;
    assign io_rise  = io_wr & ~io_wr_q;
    assign page_hit = io_rise && (cpu_addr[15:2] == 14'h3FBA);
    assign page_in  = page_hit & ~cpu_addr[1];
    assign page_out = page_hit & cpu_addr[1];

    // Shadow map sits at the top of RAM, addressed downward from TOP.
    always_comb begin
        shadow_we   = 1'b0;
        shadow_addr = TOP;
        pen_idx_d   = pen_idx_q;
        crtc_idx_d  = crtc_idx_q;
        if (io_rise && !page_hit) begin
            case (cpu_addr[15:8])
                8'h7F: begin
                    shadow_we = 1'b1;
                    case (io_dout[7:6])
                        2'b00: begin
                            shadow_addr = TOP - RAM_AW'(12'h030);
                            pen_idx_d   = io_dout[4:0];
                        end
                        2'b01: shadow_addr = pen_idx_q[4] ? TOP - RAM_AW'(12'h020)
                                           : TOP - RAM_AW'(12'h06F) + RAM_AW'(pen_idx_q[3:0]);
                        2'b10: shadow_addr = TOP - RAM_AW'(12'h010);
                        default: shadow_addr = TOP;
                    endcase
                end
                8'hBC: begin
                    shadow_we   = 1'b1;
                    shadow_addr = TOP - RAM_AW'(12'h300);
                    crtc_idx_d  = io_dout[4:0] & CRTC_MASK;
                end
                8'hBD: begin
                    shadow_we   = 1'b1;
                    shadow_addr = TOP - RAM_AW'(12'h24F) + RAM_AW'(crtc_idx_q);
                end
                8'hF7: begin
                    shadow_we   = 1'b1;
                    shadow_addr = TOP - RAM_AW'(12'h800);
                end
                8'hDF: begin
                    shadow_we   = 1'b1;
                    shadow_addr = TOP - RAM_AW'(12'h553);
                end
                default: shadow_we = 1'b0;
            endcase
        end
    end

    assign rom_en    = mf_en && (cpu_addr[15:13] == 3'b000);
    assign ram_en    = mf_en && (cpu_addr[15:13] == 3'b001);
    assign cpu_we    = ram_w & ram_en & ~page_hit & ~shadow_we;
    assign mem_we    = (shadow_we | cpu_we) & ~reset;
    assign mem_addr  = shadow_we ? shadow_addr : RAM_AW'(cpu_addr[12:0]);
    assign mem_wdata = shadow_we ? io_dout : ram_din;

    // Write-first single port: a write also returns the written byte.
    always_ff @(posedge clk_sys) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            dout_q        <= mem_wdata;
        end else begin
            dout_q <= mem[mem_addr];
        end
    end
    assign ram_dout = dout_q;

    always_comb begin
        state_d  = state_q;
        hidden_d = hidden_q;
        case (state_q)
            ST_IDLE:   if (key_rise) state_d = ST_ARMED;
            ST_ARMED:  if (m1_rise && cpu_addr == NMI_VEC) begin
                           state_d  = ST_ACTIVE;
                           hidden_d = 1'b0;
                       end
            ST_ACTIVE: if (m1_rise && cpu_addr == HIDE_VEC) hidden_d = 1'b1;
            default:   state_d = ST_IDLE;
        endcase
        // The page port overrides any same-cycle FSM event.
        if (page_out) begin
            state_d = ST_IDLE;
        end else if (page_in) begin
            if (!hidden_q)                  state_d = ST_ACTIVE;
            else if (state_q == ST_ACTIVE)  state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hidden_q   <= 1'b0;
            pen_idx_q  <= '0;
            crtc_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            hidden_q   <= hidden_d;
            pen_idx_q  <= pen_idx_d;
            crtc_idx_q <= crtc_idx_d;
        end
    end

    assign nmi       = (state_q == ST_ARMED);
    assign mf_en     = (state_q == ST_ACTIVE);
    assign mf_hidden = hidden_q;

endmodule
